// File: rtl/input_line_buffer.sv
// input_line_buffer: collects DATA_W-bit characters, one per rising edge of
// `received`, into a DEPTH-entry shift buffer (newest entry in the low lane).
// A TERM_CODE character commits the line, which is held until line_ack.
// OVF_MODE selects the full-buffer policy: 0 drops the new character,
// 1 shifts it in and loses the oldest entry.
// DATA_W must be at least 8 so that the 8-bit control codes fit.
// Optional feature macro: BACKSPACE_EN (BS_CODE removes the newest entry).
module input_line_buffer #(
  parameter int unsigned         DATA_W    = 8,
  parameter int unsigned         DEPTH     = 15,
  parameter logic [DATA_W-1:0]   TERM_CODE = 'h0D,
  parameter logic [DATA_W-1:0]   BS_CODE   = 'h08,
  parameter int unsigned         OVF_MODE  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             received,
  input  logic                             line_ack,
  input  logic                             clear,
  output logic [DATA_W*DEPTH-1:0]          in_q,
  output logic [DATA_W-1:0]                last_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             line_valid,
  output logic                             overflow
);

  localparam int unsigned QW    = DATA_W * DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

`ifdef BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  logic       last_rec;
  logic       evt;
  logic       is_term;
  logic       is_bs;
  logic [QW-1:0] shifted_in;

  assign evt        = received & ~last_rec;
  assign is_term    = (data_in == TERM_CODE);
  assign is_bs      = BS_EN && (data_in == BS_CODE);
  assign shifted_in = (in_q << DATA_W) | QW'(data_in);

  assign last_data  = in_q[DATA_W-1:0];
  assign full       = (count == CNT_W'(DEPTH));

  // Strobe history; tracks received through reset and clear so a held strobe never fires
  always_ff @(posedge clk) begin
    last_rec <= received;
  end

  // Line collection FSM with buffer, fill count, commit flag and discard pulse
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= COLLECT;
      in_q       <= '0;
      count      <= '0;
      line_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        HOLD: begin
          if (line_ack) begin
            // Release the line; a coincident event is dropped silently
            in_q       <= '0;
            count      <= '0;
            line_valid <= 1'b0;
            state      <= COLLECT;
          end else if (evt) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          if (evt) begin
            if (is_term) begin
              line_valid <= 1'b1;
              state      <= HOLD;
            end else if (is_bs) begin
              if (count != '0) begin
                in_q  <= in_q >> DATA_W;
                count <= count - CNT_W'(1);
              end
            end else if (count < CNT_W'(DEPTH)) begin
              in_q  <= shifted_in;
              count <= count + CNT_W'(1);
            end else begin
              overflow <= 1'b1;
              if (OVF_MODE == 1) begin
                in_q <= shifted_in;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_line_buffer.sv
// Bench for input_line_buffer: two instances (drop and shift-out overflow
// policies) share one stimulus stream; expected snapshots are queued per
// instance as stimulus is driven and popped when the result is sampled.
module tb_input_line_buffer;

  typedef struct packed {
    logic [31:0] q;
    logic [2:0]  cnt;
    logic        lv;
    logic        full;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        received = 1'b0;
  logic        line_ack = 1'b0;
  logic        clear = 1'b0;

  logic [31:0] q0, q1;
  logic [7:0]  ld0, ld1;
  logic [2:0]  cnt0, cnt1;
  logic        full0, full1, lv0, lv1, ovf0, ovf1;
  snap_t       snap0, snap1;

  int n_vec  = 0;
  int n_fail = 0;
  int p0 = 0;
  int p1 = 0;
  snap_t sb0[$];
  snap_t sb1[$];

  always #5 clk = ~clk;

  input_line_buffer #(.DATA_W(8), .DEPTH(4), .OVF_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .received(received),
    .line_ack(line_ack), .clear(clear), .in_q(q0), .last_data(ld0),
    .count(cnt0), .full(full0), .line_valid(lv0), .overflow(ovf0));

  input_line_buffer #(.DATA_W(8), .DEPTH(4), .OVF_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .received(received),
    .line_ack(line_ack), .clear(clear), .in_q(q1), .last_data(ld1),
    .count(cnt1), .full(full1), .line_valid(lv1), .overflow(ovf1));

  assign snap0 = {q0, cnt0, lv0, full0};
  assign snap1 = {q1, cnt1, lv1, full1};

  // One cycle, sampled away from the active edge; tallies overflow pulses
  task automatic tick();
    @(negedge clk);
    if (ovf0 === 1'b1) p0++;
    if (ovf1 === 1'b1) p1++;
  endtask

  task automatic strobe(input logic [7:0] d, input int hold);
    data_in  = d;
    received = 1'b1;
    repeat (hold) tick();
    received = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic expect_both(input snap_t e0, input snap_t e1);
    sb0.push_back(e0);
    sb1.push_back(e1);
  endtask

  task automatic test_reset();
    snap_t e;
    rst = 1'b1;
    expect_both('0, '0);
    repeat (3) tick();
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL reset dut0 got %h want %h", snap0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL reset dut1 got %h want %h", snap1, e); end
    n_vec++;
    if ({ovf0, ovf1} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf got %b want 00", {ovf0, ovf1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push();
    snap_t e;
    do_clear();
    expect_both({32'h00414243, 3'd3, 1'b0, 1'b0}, {32'h00414243, 3'd3, 1'b0, 1'b0});
    strobe(8'h41, 5);
    strobe(8'h42, 1);
    strobe(8'h43, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL push dut0 got %h want %h", snap0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL push dut1 got %h want %h", snap1, e); end
    n_vec++;
    if (ld0 !== 8'h43) begin n_fail++; $display("FAIL push_last got %h want 43", ld0); end
  endtask

  task automatic test_overflow();
    snap_t e;
    int a0, a1;
    do_clear();
    for (int i = 0; i < 4; i++) strobe(8'h31 + 8'(i), 1);
    a0 = p0; a1 = p1;
    n_vec++;
    if ((a0 !== 0) || (a1 !== 0)) begin n_fail++; $display("FAIL ovf_early got %0d/%0d want 0/0", a0, a1); end
    expect_both({32'h31323334, 3'd4, 1'b0, 1'b1}, {32'h32333435, 3'd4, 1'b0, 1'b1});
    strobe(8'h35, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL ovf_drop got %h want %h", snap0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL ovf_shift got %h want %h", snap1, e); end
    tick();
    n_vec++;
    if ((p0 - a0 !== 1) || (p1 - a1 !== 1)) begin
      n_fail++; $display("FAIL ovf_pulse got %0d/%0d want 1/1", p0 - a0, p1 - a1);
    end
  endtask

  task automatic test_line();
    snap_t e;
    int a0, a1;
    do_clear();
    strobe(8'h41, 1);
    expect_both({32'h00000041, 3'd1, 1'b1, 1'b0}, {32'h00000041, 3'd1, 1'b1, 1'b0});
    strobe(8'h0D, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL commit dut0 got %h want %h", snap0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL commit dut1 got %h want %h", snap1, e); end
    a0 = p0; a1 = p1;
    expect_both({32'h00000041, 3'd1, 1'b1, 1'b0}, {32'h00000041, 3'd1, 1'b1, 1'b0});
    strobe(8'h42, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || p0 - a0 !== 1) begin n_fail++; $display("FAIL hold_drop got %h/%0d want %h/1", snap0, p0 - a0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e || p1 - a1 !== 1) begin n_fail++; $display("FAIL hold_drop1 got %h/%0d want %h/1", snap1, p1 - a1, e); end
    expect_both('0, '0);
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL ack got %h want %h", snap0, e); end
    void'(sb1.pop_front());
    expect_both({32'h00000044, 3'd1, 1'b0, 1'b0}, {32'h00000044, 3'd1, 1'b0, 1'b0});
    strobe(8'h44, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL after_ack got %h want %h", snap0, e); end
    void'(sb1.pop_front());
    // Event coincident with line_ack: released without a discard pulse
    strobe(8'h0D, 1);
    a0 = p0;
    expect_both('0, '0);
    data_in = 8'h55; received = 1'b1; line_ack = 1'b1;
    tick();
    line_ack = 1'b0; received = 1'b0;
    tick();
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || p0 - a0 !== 0) begin n_fail++; $display("FAIL ack_evt got %h/%0d want %h/0", snap0, p0 - a0, e); end
    void'(sb1.pop_front());
  endtask

  task automatic test_backspace();
    snap_t e;
    int a0;
    do_clear();
    strobe(8'h41, 1);
    strobe(8'h42, 1);
`ifdef BACKSPACE_EN
    expect_both({32'h00000041, 3'd1, 1'b0, 1'b0}, {32'h00000041, 3'd1, 1'b0, 1'b0});
    strobe(8'h08, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL bs_one got %h want %h", snap0, e); end
    void'(sb1.pop_front());
    a0 = p0;
    expect_both('0, '0);
    strobe(8'h08, 1);
    strobe(8'h08, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || p0 - a0 !== 0) begin n_fail++; $display("FAIL bs_empty got %h/%0d want %h/0", snap0, p0 - a0, e); end
    void'(sb1.pop_front());
`else
    a0 = p0;
    expect_both({32'h00414208, 3'd3, 1'b0, 1'b0}, {32'h00414208, 3'd3, 1'b0, 1'b0});
    strobe(8'h08, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || p0 - a0 !== 0) begin n_fail++; $display("FAIL bs_data got %h/%0d want %h/0", snap0, p0 - a0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL bs_data1 got %h want %h", snap1, e); end
`endif
  endtask

  task automatic test_reset_hold();
    snap_t e;
    int a0;
    do_clear();
    strobe(8'h41, 1);
    strobe(8'h0D, 1);
    data_in = 8'h5A; received = 1'b1; rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    a0 = p0;
    expect_both('0, '0);
    repeat (3) tick();
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || p0 - a0 !== 0) begin n_fail++; $display("FAIL rst_held got %h/%0d want %h/0", snap0, p0 - a0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL rst_held1 got %h want %h", snap1, e); end
    received = 1'b0;
    tick();
    expect_both({32'h00000061, 3'd1, 1'b0, 1'b0}, {32'h00000061, 3'd1, 1'b0, 1'b0});
    strobe(8'h61, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL rst_rearm got %h want %h", snap0, e); end
    void'(sb1.pop_front());
  endtask

  task automatic test_clear();
    snap_t e;
    do_clear();
    strobe(8'h11, 1);
    strobe(8'h22, 1);
    expect_both('0, '0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL clear got %h want %h", snap0, e); end
    void'(sb1.pop_front());
    expect_both({32'h00000033, 3'd1, 1'b0, 1'b0}, {32'h00000033, 3'd1, 1'b0, 1'b0});
    strobe(8'h33, 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e || ld0 !== 8'h33) begin n_fail++; $display("FAIL clear_push got %h/%h want %h/33", snap0, ld0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL clear_push1 got %h want %h", snap1, e); end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    do_clear();
    expect_both({32'hA1A2A3A4, 3'd4, 1'b0, 1'b1}, {32'hA1A2A3A4, 3'd4, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) strobe(8'hA1 + 8'(i), 1);
    e = sb0.pop_front(); n_vec++;
    if (snap0 !== e) begin n_fail++; $display("FAIL b2b dut0 got %h want %h", snap0, e); end
    e = sb1.pop_front(); n_vec++;
    if (snap1 !== e) begin n_fail++; $display("FAIL b2b dut1 got %h want %h", snap1, e); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_overflow();
    test_line();
    test_backspace();
    test_reset_hold();
    test_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
